// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed common-anode seven-segment scanner with frame snapshot,
// leading-zero blanking, brightness PWM and anode dead time. Define SEG_BLINK_EN for blink.
module seg_scan_ctrl #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 100000,
   parameter int DEAD_CYC     = 16,
   parameter int BLINK_FRAMES = 250
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [4*DIGITS-1:0] value,
   input  logic [DIGITS-1:0]   dp,
   input  logic [DIGITS-1:0]   blank,
`ifdef SEG_BLINK_EN
   input  logic [DIGITS-1:0]   blink,
`endif
   input  logic                lz_blank,
   input  logic [3:0]          brightness,
   output logic [6:0]          seg,
   output logic                dp_n,
   output logic [DIGITS-1:0]   en_seg_n,
   output logic                frame_tick
);
   localparam int SLICE = (SCAN_DIV - DEAD_CYC) / 16;
   localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PCNT_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);
   localparam logic [31:0]   DEAD_START = 32'(DEAD_CYC);

   if (DIGITS < 1 || DIGITS > 8 || SCAN_DIV < DEAD_CYC + 16 || BLINK_FRAMES < 1) begin : g_param_check
      $error("seg_scan_ctrl: illegal parameter combination");
   end

   logic [PW-1:0]         pcnt;
   logic [DW-1:0]         dig;
   logic [4*DIGITS-1:0]   snap_value, eff_value;
   logic [DIGITS-1:0]     snap_dp, eff_dp, snap_blank, eff_blank, lz_mask;
   logic                  snap_lz, eff_lz;
   logic [3:0]            snap_bright, eff_bright, nibble;
   logic                  snap_event, slot_end, frame_end;
   logic                  zero_above, lit, blink_off, visible;
   logic [31:0]           pos, lit_end;

   function automatic logic [6:0] hex_font(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   assign slot_end   = (pcnt == PCNT_LAST);
   assign frame_end  = slot_end && (dig == DIG_LAST);
   assign snap_event = (pcnt == '0) && (dig == '0);

   // On the snapshot cycle itself the fresh inputs are already the frame's contents.
   assign eff_value  = snap_event ? value      : snap_value;
   assign eff_dp     = snap_event ? dp         : snap_dp;
   assign eff_blank  = snap_event ? blank      : snap_blank;
   assign eff_lz     = snap_event ? lz_blank   : snap_lz;
   assign eff_bright = snap_event ? brightness : snap_bright;

   always_comb begin
      // NOTE: every variable gets a default before the loop so no path holds a stale value (no latch).
      lz_mask    = '0;
      zero_above = 1'b1;
      for (int d = DIGITS - 1; d >= 1; d--) begin
         zero_above = zero_above && (eff_value[4*d +: 4] == 4'h0);
         lz_mask[d] = eff_lz && zero_above;
      end
   end

   assign nibble  = eff_value[{dig, 2'b00} +: 4];
   assign pos     = 32'(pcnt);
   assign lit_end = DEAD_START + (32'(eff_bright) + 32'd1) * 32'(SLICE);
   assign lit     = (pos >= DEAD_START) && (pos < lit_end);
   assign visible = lit && !eff_blank[dig] && !lz_mask[dig] && !blink_off;

`ifdef SEG_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

   logic [BW-1:0]     bcnt;
   logic              phase_on;
   logic [DIGITS-1:0] snap_blink, eff_blink;

   // Phase flips on a frame boundary, so it is constant across every displayed frame.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bcnt       <= '0;
         phase_on   <= 1'b1;
         snap_blink <= '0;
      end else begin
         if (frame_end) begin
            if (bcnt == BCNT_LAST) begin
               bcnt     <= '0;
               phase_on <= !phase_on;
            end else begin
               bcnt <= bcnt + 1'b1;
            end
         end
         if (snap_event) snap_blink <= blink;
      end
   end

   assign eff_blink = snap_event ? blink : snap_blink;
   assign blink_off = !phase_on && eff_blink[dig];
`else
   assign blink_off = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pcnt        <= '0;
         dig         <= '0;
         snap_value  <= '0;
         snap_dp     <= '0;
         snap_blank  <= '1;
         snap_lz     <= 1'b0;
         snap_bright <= '0;
         seg         <= 7'h7F;
         dp_n        <= 1'b1;
         en_seg_n    <= '1;
         frame_tick  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge state.
         pcnt <= slot_end ? '0 : pcnt + 1'b1;
         if (slot_end) dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
         if (snap_event) begin
            snap_value  <= value;
            snap_dp     <= dp;
            snap_blank  <= blank;
            snap_lz     <= lz_blank;
            snap_bright <= brightness;
         end
         frame_tick <= snap_event;
         if (visible) begin
            seg      <= hex_font(nibble);
            dp_n     <= !eff_dp[dig];
            en_seg_n <= ~(DIGITS'(1) << dig);
         end else begin
            seg      <= 7'h7F;
            dp_n     <= 1'b1;
            en_seg_n <= '1;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench; a frame-level reference model predicts every
// output cycle, a monitor pops and compares. Build with SEG_BLINK_EN to cover blink.
module tb_seg_scan_ctrl;
   localparam int DIGITS       = 4;
   localparam int SCAN_DIV     = 64;
   localparam int DEAD_CYC     = 16;
   localparam int BLINK_FRAMES = 2;
   localparam int SLICE        = (SCAN_DIV - DEAD_CYC) / 16;
   localparam int FRAME        = DIGITS * SCAN_DIV;
`ifdef SEG_BLINK_EN
   localparam bit BLINK_EN = 1'b1;
`else
   localparam bit BLINK_EN = 1'b0;
`endif

   typedef struct packed {
      logic [6:0] seg;
      logic       dp_n;
      logic [3:0] en;
      logic       ft;
   } out_t;

   localparam out_t IDLE = '{seg: 7'h7F, dp_n: 1'b1, en: 4'hF, ft: 1'b0};
   localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0, blank = '0, blink = '0;
   logic        lz_blank = 1'b0;
   logic [3:0]  brightness = '0;
   logic [6:0]  seg;
   logic        dp_n;
   logic [3:0]  en_seg_n;
   logic        frame_tick;

   seg_scan_ctrl #(
      .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD_CYC(DEAD_CYC), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clock(clock), .reset_n(reset_n), .value(value), .dp(dp), .blank(blank),
`ifdef SEG_BLINK_EN
      .blink(blink),
`endif
      .lz_blank(lz_blank), .brightness(brightness),
      .seg(seg), .dp_n(dp_n), .en_seg_n(en_seg_n), .frame_tick(frame_tick)
   );

   always #5 clock = ~clock;

   int   n_checks = 0;
   int   n_pass = 0;
   out_t exp_q[$];
   int unsigned t = 0;

   logic [15:0] s_value;
   logic [3:0]  s_dp, s_blank, s_blink, s_bright;
   logic        s_lz;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
   endtask

   // Reference: t counts cycles since reset release; output after edge t+1 reflects state t.
   task automatic model_step();
      out_t        e;
      int unsigned f, slot, p;
      bit          vis;
      e = IDLE;
      if (!reset_n) begin
         t = 0;
         exp_q.push_back(e);
         return;
      end
      if (t % FRAME == 0) begin
         s_value = value; s_dp = dp; s_blank = blank; s_blink = blink;
         s_lz = lz_blank; s_bright = brightness;
      end
      f    = t / FRAME;
      slot = (t / SCAN_DIV) % DIGITS;
      p    = t % SCAN_DIV;
      e.ft = (t % FRAME == 0);
      vis  = (p >= DEAD_CYC) && (p < DEAD_CYC + (int'(s_bright) + 1) * SLICE);
      if (s_blank[slot]) vis = 0;
      if (s_lz && slot != 0 && (s_value >> (4 * slot)) == 0) vis = 0;
      if (BLINK_EN && ((f / BLINK_FRAMES) % 2 == 1) && s_blink[slot]) vis = 0;
      if (vis) begin
         e.en   = ~(4'b0001 << slot);
         e.seg  = FONT[s_value[4*slot +: 4]];
         e.dp_n = ~s_dp[slot];
      end
      exp_q.push_back(e);
      t++;
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   initial forever begin
      out_t e;
      @(negedge clock);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pins", 32'({seg, dp_n, en_seg_n, frame_tick}), 32'(e));
         check("one_anode", 32'($countones(~en_seg_n) <= 1), 32'd1);
      end
   end

   task automatic wait_pos(input int unsigned where);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while ((t % FRAME) != where && n < 2 * FRAME);
      check("wait_pos_reached", t % FRAME, where);
   endtask

   task automatic run_frames(input int n);
      repeat (n * FRAME) @(negedge clock);
   endtask

   task automatic rand_inputs();
      int unsigned lead = $urandom_range(0, DIGITS);
      logic [15:0] v = 16'($urandom);
      for (int d = DIGITS - int'(lead); d < DIGITS; d++) v[4*d +: 4] = 4'h0;
      value      = v;
      dp         = 4'($urandom);
      blank      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      blink      = 4'($urandom);
      lz_blank   = 1'($urandom);
      brightness = 4'($urandom);
   endtask

   task automatic mid_slot_reset();
      wait_pos(SCAN_DIV + DEAD_CYC + 5);
      #1 reset_n = 1'b0;
      #1 check("reset_async_blank", 32'({seg, dp_n, en_seg_n, frame_tick}), 32'(IDLE));
      repeat (3) @(negedge clock);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      value = 16'h1234; brightness = 4'd15; dp = 4'b0010; lz_blank = 1'b0;
      repeat (10) @(negedge clock);
      #1 reset_n = 1'b1;
      run_frames(2);

      wait_pos(0);
      brightness = 4'd0;
      run_frames(2);

      wait_pos(0);
      brightness = 4'd15; lz_blank = 1'b1; value = 16'h0050;
      run_frames(2);
      wait_pos(0);
      value = 16'h0000;
      run_frames(2);

      wait_pos(0);
      lz_blank = 1'b0; value = 16'h1111;
      wait_pos(SCAN_DIV + 10);
      value = 16'h2222;
      run_frames(2);

      wait_pos(0);
      value = 16'hA5C3; blink = 4'b0001; brightness = 4'd9;
      run_frames(8);

      mid_slot_reset();
      run_frames(1);

      for (int i = 0; i < 20 * FRAME; i++) begin
         @(negedge clock);
         if ($urandom_range(0, 39) == 0) rand_inputs();
      end
      mid_slot_reset();
      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clock);
         if ($urandom_range(0, 29) == 0) rand_inputs();
      end

      repeat (2) @(negedge clock);
      #1 check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
